i2c_scl_generator: RTL and testbench
====================================

# i2c_scl_generator

Programmable SCL timing generator for the I2C master core, in the `i2c_core_clk_i` domain. It sits directly downstream of the APB register block and consumes the synchronized prescale value. It produces the SCL line drive plus single-cycle phase ticks that the byte/bit sequencer uses to change SDA mid-low and sample SDA mid-high. An optional mode holds SCL high-phase timing while a slave stretches the clock.

## Interface
Parameters:
- `PRESCALE_WIDTH`, default 8: width of the prescale value and of the phase counter.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `i2c_core_clk_i`  in  1: I2C core clock; the only clock.
- `i2c_core_rst_i`  in  1: synchronous, active-high reset.
- `prescale_i`  in  PRESCALE_WIDTH: synchronized prescale register value P.
- `clk_en_i`  in  1: request to run SCL; level, from the core sequencer.
- `scl_i`  in  1: sensed SCL pad level, asynchronous. Used only with `I2C_CLK_STRETCH_EN`.
- `scl_o`  out  1: SCL drive level (1 = release/high, 0 = pull low).
- `scl_fall_tick_o`  out  1: pulse in the first cycle of phase L1.
- `sda_change_tick_o`  out  1: pulse in the first cycle of phase L2 (mid-low).
- `scl_rise_tick_o`  out  1: pulse in the first cycle of phase H1.
- `sda_sample_tick_o`  out  1: pulse in the first cycle of phase H2 (mid-high).
- `busy_o`  out  1: high whenever the phase is not IDLE.
- `stretching_o`  out  1: high while H1 is held because synchronized SCL is low. Constant 0 without the macro.

## Operation
- States: IDLE, L1, L2, H1, H2. `scl_o` = 0 in L1/L2 and 1 in IDLE/H1/H2.
- Phase counter `cnt` is PRESCALE_WIDTH bits wide. `p_q` is the latched prescale.
- IDLE: `cnt` = 0. When `clk_en_i` = 1, go to L1, load `cnt` = `prescale_i` and `p_q` = `prescale_i`.
- L1, L2, H1, H2 each last P+1 cycles:
  - If `cnt` != 0, decrement `cnt`.
  - If `cnt` = 0, advance to the next phase and reload `cnt` = `p_q`.
- L1 → L2 → H1 → H2.
- At the end of H2:
  - `clk_en_i` = 1: go to L1, re-latch `p_q`/`cnt` from `prescale_i`.
  - `clk_en_i` = 0: go to IDLE.
- `p_q` changes only on entry to L1, so a prescale change takes effect at the next period boundary. A period never contains mixed phase lengths.
- Deasserting `clk_en_i` mid-period does not truncate the period. The current period completes through H2, then the block goes to IDLE with `scl_o` = 1.
- Ticks are registered. Each tick asserts for exactly one cycle, the first cycle of its phase. Ticks are mutually exclusive.
- P = 0 is legal: each phase lasts 1 cycle, giving a 4-cycle period with ticks on consecutive cycles.
- P = 2^PRESCALE_WIDTH−1 is legal. `cnt` never wraps below 0.
- Reset (any state, any cycle): on the next rising edge, the block is in IDLE with:
  - `scl_o` = 1
  - all ticks, `busy_o` and `stretching_o` = 0
  - `cnt` = 0, `p_q` = 0

## Timing
- Start latency: `clk_en_i` sampled high in IDLE at edge N. At edge N, `scl_o` = 0 and `scl_fall_tick_o` = 1, both visible in cycle N.
- Period without stretch: 4·(P+1) cycles. Duty cycle: low 2·(P+1), high 2·(P+1).
- Relative to the L1 start, `sda_change_tick_o` fires at +(P+1), `scl_rise_tick_o` at +2(P+1), `sda_sample_tick_o` at +3(P+1).
- `busy_o` rises with L1 entry and falls on the IDLE entry edge.
- `clk_en_i` is sampled only in IDLE and in the last cycle of H2.

## Configuration
- `I2C_CLK_STRETCH_EN` defined:
  - `scl_i` passes through a 2-flop synchronizer (reset value 1).
  - In H1, `cnt` decrements only when synchronized SCL = 1. Otherwise it holds and `stretching_o` = 1.
  - Because of synchronizer latency, an unstretched H1 lasts P+3 cycles, so the period is 4·(P+1)+2.
  - While SCL is held low externally, H1 is extended indefinitely. `sda_sample_tick_o` is delayed accordingly.
- Not defined:
  - `scl_i` is ignored and no synchronizer is built.
  - `stretching_o` is tied to 0.
  - The period is exactly 4·(P+1).

## Test plan
- Reset, then P=3, `clk_en_i`=1 held for 3 periods → `scl_o` low 8 / high 8 cycles. Ticks at offsets 0, 4, 8, 12 in each 16-cycle period. `busy_o`=1 throughout.
- P=0 → 4-cycle period; fall, change, rise and sample ticks on 4 consecutive cycles; no tick overlap.
- P=5; drop `clk_en_i` during L2 → period finishes at 24 cycles, then IDLE with `scl_o`=1 and `busy_o`=0. Change P 5→1 during H1 → the next period is 8 cycles, the current one stays 24.
- Assert `i2c_core_rst_i` for 1 cycle during H1 with P=7 → next cycle IDLE, `scl_o`=1, no ticks. Restart yields a full 32-cycle first period.
- With `I2C_CLK_STRETCH_EN`, P=2: `scl_i` follows `scl_o` → period 14 cycles. Hold `scl_i`=0 for 10 cycles after the rise tick → `stretching_o`=1 for those cycles plus sync latency, and `sda_sample_tick_o` is delayed by 10 cycles.
- Without the macro, toggle `scl_i` randomly → timing identical to the no-stretch case and `stretching_o` stays 0.

Source files
------------

// File: rtl/i2c_scl_generator.sv
// i2c_scl_generator
// Programmable SCL timing generator for the I2C master core (i2c_core_clk_i domain).
// One SCL period is four phases L1, L2, H1, H2. Each phase lasts P+1 cycles, where P
// is the prescale value latched at the start of the period. Single-cycle ticks mark
// the first cycle of each phase for the bit sequencer.
//
// Optional feature macro: I2C_CLK_STRETCH_EN
//   When defined, scl_i is synchronized and H1 holds while the synchronized SCL is low
//   (slave clock stretching).
//   When undefined, scl_i is ignored and stretching_o is tied low.
//
// Ports:
//   i2c_core_clk_i     core clock
//   i2c_core_rst_i     synchronous active-high reset
//   prescale_i         prescale value P, latched only at period start
//   clk_en_i           run request, sampled in IDLE and in the last cycle of H2
//   scl_i              sensed SCL pad level (asynchronous, stretch mode only)
//   scl_o              SCL drive level (1 = release, 0 = pull low)
//   scl_fall_tick_o    first cycle of L1
//   sda_change_tick_o  first cycle of L2
//   scl_rise_tick_o    first cycle of H1
//   sda_sample_tick_o  first cycle of H2
//   busy_o             phase is not IDLE
//   stretching_o       H1 held by a low synchronized SCL
module i2c_scl_generator #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      i2c_core_clk_i,
    input  logic                      i2c_core_rst_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      clk_en_i,
    input  logic                      scl_i,
    output logic                      scl_o,
    output logic                      scl_fall_tick_o,
    output logic                      sda_change_tick_o,
    output logic                      scl_rise_tick_o,
    output logic                      sda_sample_tick_o,
    output logic                      busy_o,
    output logic                      stretching_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_H1   = 3'd3,
        ST_H2   = 3'd4
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] CNT_ZERO = PRESCALE_WIDTH'(0);
    localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE  = PRESCALE_WIDTH'(1);

    state_t                    state_r;
    state_t                    state_s;
    logic [PRESCALE_WIDTH-1:0] cnt_r;
    logic [PRESCALE_WIDTH-1:0] cnt_s;
    logic [PRESCALE_WIDTH-1:0] p_r;
    logic [PRESCALE_WIDTH-1:0] p_s;
    logic                      scl_hi_s;       // synchronized SCL, current cycle
    logic                      scl_hi_next_s;  // synchronized SCL, next cycle
    logic                      hold_s;

    logic scl_r;
    logic fall_tick_r;
    logic change_tick_r;
    logic rise_tick_r;
    logic sample_tick_r;
    logic busy_r;
    logic stretching_r;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync_r;

    // Two-flop synchronizer for the asynchronous SCL pad level; idles high.
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            scl_sync_r <= 2'b11;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_i};
        end
    end

    assign scl_hi_s      = scl_sync_r[1];
    // The first stage is what the second stage shows next cycle, which lets the
    // registered stretching flag line up with the cycles that H1 actually holds.
    assign scl_hi_next_s = scl_sync_r[0];
`else
    logic unused_scl_s;
    assign unused_scl_s  = scl_i;
    assign scl_hi_s      = 1'b1;
    assign scl_hi_next_s = 1'b1;
`endif

    // H1 only advances while the line is actually seen high.
    assign hold_s = (state_r == ST_H1) && !scl_hi_s;

    // Next-state, phase counter and prescale latch.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        p_s     = p_r;
        case (state_r)
            ST_IDLE: begin
                if (clk_en_i) begin
                    state_s = ST_L1;
                    cnt_s   = prescale_i;
                    p_s     = prescale_i;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_L1, ST_L2, ST_H1, ST_H2: begin
                if (hold_s) begin
                    cnt_s = cnt_r;
                end else if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (state_r == ST_H2) begin
                    // Period boundary: the only place a new prescale is accepted.
                    if (clk_en_i) begin
                        state_s = ST_L1;
                        cnt_s   = prescale_i;
                        p_s     = prescale_i;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end else begin
                    cnt_s = p_r;
                    case (state_r)
                        ST_L1:   state_s = ST_L2;
                        ST_L2:   state_s = ST_H1;
                        ST_H1:   state_s = ST_H2;
                        default: state_s = ST_IDLE;
                    endcase
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                p_s     = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; outputs are derived from the next state
    // so they change on the same edge as the phase.
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            p_r           <= CNT_ZERO;
            scl_r         <= 1'b1;
            fall_tick_r   <= 1'b0;
            change_tick_r <= 1'b0;
            rise_tick_r   <= 1'b0;
            sample_tick_r <= 1'b0;
            busy_r        <= 1'b0;
            stretching_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            p_r           <= p_s;
            scl_r         <= !((state_s == ST_L1) || (state_s == ST_L2));
            // H2 -> L1 is a real transition, so back-to-back periods still tick.
            fall_tick_r   <= (state_s == ST_L1) && (state_r != ST_L1);
            change_tick_r <= (state_s == ST_L2) && (state_r != ST_L2);
            rise_tick_r   <= (state_s == ST_H1) && (state_r != ST_H1);
            sample_tick_r <= (state_s == ST_H2) && (state_r != ST_H2);
            busy_r        <= (state_s != ST_IDLE);
            stretching_r  <= (state_s == ST_H1) && !scl_hi_next_s;
        end
    end

    assign scl_o             = scl_r;
    assign scl_fall_tick_o   = fall_tick_r;
    assign sda_change_tick_o = change_tick_r;
    assign scl_rise_tick_o   = rise_tick_r;
    assign sda_sample_tick_o = sample_tick_r;
    assign busy_o            = busy_r;
    assign stretching_o      = stretching_r;

endmodule

// File: tb/tb_i2c_scl_generator.sv
module tb_i2c_scl_generator;

    localparam int W = 8;
`ifdef I2C_CLK_STRETCH_EN
    localparam int X = 2;   // synchronizer latency added to every H1
`else
    localparam int X = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         ext_low = 1'b0;
    logic         rnd = 1'b0;
    logic [W-1:0] prescale = 8'd0;
    logic         scl_i;
    logic         scl_o, fall, chg, rise, smp, busy, str;
    logic         chk_en = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

`ifdef I2C_CLK_STRETCH_EN
    assign scl_i = scl_o & ~ext_low;
`else
    assign scl_i = rnd;
`endif

    always #5 clk = ~clk;

    i2c_scl_generator #(.PRESCALE_WIDTH(W)) dut (
        .i2c_core_clk_i   (clk),
        .i2c_core_rst_i   (rst),
        .prescale_i       (prescale),
        .clk_en_i         (en),
        .scl_i            (scl_i),
        .scl_o            (scl_o),
        .scl_fall_tick_o  (fall),
        .sda_change_tick_o(chg),
        .scl_rise_tick_o  (rise),
        .sda_sample_tick_o(smp),
        .busy_o           (busy),
        .stretching_o     (str)
    );

    // Random pad activity; only consumed in the non-stretch build.
    always @(negedge clk) rnd = 1'($urandom_range(0, 1));

    // Period model: position within the current period plus stall cycles spent in H1.
    bit m_act = 1'b0;
    int m_t = 0;
    int m_p = 0;
    int m_hold = 0;
    bit s0 = 1'b1;
    bit s1 = 1'b1;
    int mL, me;
    bit mstall;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            s0 = 1'b1;
            s1 = 1'b1;
        end else begin
            if (m_act) begin
                mL = m_p + 1;
                me = m_t - m_hold;
`ifdef I2C_CLK_STRETCH_EN
                mstall = (me >= 2*mL) && (me < 3*mL) && !s1;
`else
                mstall = 1'b0;
`endif
                if (mstall) begin
                    m_hold++;
                    m_t++;
                end else if (me == 4*mL - 1) begin
                    if (en) begin
                        m_t = 0; m_p = int'(prescale); m_hold = 0;
                    end else begin
                        m_act = 1'b0;
                    end
                end else begin
                    m_t++;
                end
            end else if (en) begin
                m_act = 1'b1; m_t = 0; m_p = int'(prescale); m_hold = 0;
            end
            s1 = s0;
            s0 = scl_i;
        end
    end

    // Per-cycle comparison against the model.
    logic [6:0] exp_v, act_v;
    int cL, ce;
    always @(negedge clk) begin
        if (chk_en) begin
            if (!m_act) begin
                exp_v = 7'b1000000;
            end else begin
                cL = m_p + 1;
                ce = m_t - m_hold;
                exp_v[6] = (ce >= 2*cL);
                exp_v[5] = (m_t == 0);
                exp_v[4] = (ce == cL);
                exp_v[3] = (ce == 2*cL) && (m_hold == 0);
                exp_v[2] = (ce == 3*cL);
                exp_v[1] = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
                exp_v[0] = (ce >= 2*cL) && (ce < 3*cL) && !s1;
`else
                exp_v[0] = 1'b0;
`endif
            end
            act_v = {scl_o, fall, chg, rise, smp, busy, str};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t {scl,fall,chg,rise,smp,busy,str} got %b expected %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_fall();
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!fall && i < 300);
        check("wait_fall_timeout", int'(fall), 1);
    endtask

    // Called at a fall-tick cycle; counts to the next fall tick.
    task automatic period_len(output int n, output int tc, output int tr,
                              output int ts, output int low);
        n = 0; tc = -1; tr = -1; ts = -1; low = 1;
        do begin
            @(negedge clk);
            n++;
            if (chg) tc = n;
            if (rise) tr = n;
            if (smp) ts = n;
            if (!scl_o && !fall) low++;
        end while (!fall && n < 300);
    endtask

    task automatic measure(input string nm, input int e_chg, input int e_rise,
                           input int e_smp, input int e_per, input int e_low);
        int n, tc, tr, ts, low;
        wait_fall();
        period_len(n, tc, tr, ts, low);
        check({nm, "_chg"}, tc, e_chg);
        check({nm, "_rise"}, tr, e_rise);
        check({nm, "_smp"}, ts, e_smp);
        check({nm, "_per"}, n, e_per);
        check({nm, "_low"}, low, e_low);
    endtask

    initial begin
        int n, k, tc, tr, ts, low, sc;
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_scl", int'(scl_o), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ticks", int'({fall, chg, rise, smp, str}), 0);
        rst = 1'b0;

        // P=3, three periods back to back.
        prescale = 8'd3;
        en = 1'b1;
        for (int i = 0; i < 3; i++) measure("p3", 4, 8, 12 + X, 16 + X, 8);

        // P=0: ticks on consecutive cycles.
        prescale = 8'd0;
        measure("p0", 1, 2, 3 + X, 4 + X, 2);

        // P=5, drop clk_en_i during L2: period still completes.
        prescale = 8'd5;
        wait_fall();
        n = 1;
        repeat (7) begin
            @(negedge clk);
            if (busy) n++;
        end
        en = 1'b0;
        do begin
            @(negedge clk);
            if (busy) n++;
        end while (busy && n < 300);
        check("p5_drop_busy_len", n, 24 + X);
        check("p5_drop_idle_scl", int'(scl_o), 1);
        repeat (3) @(negedge clk);
        check("p5_drop_idle_busy", int'(busy), 0);

        // P=5 then change to 1 during H1: current period unaffected.
        en = 1'b1;
        wait_fall();
        repeat (13) @(negedge clk);
        prescale = 8'd1;
        k = 13;
        do begin
            @(negedge clk);
            k++;
        end while (!fall && k < 300);
        check("p5_to_p1_cur_per", k, 24 + X);
        period_len(n, tc, tr, ts, low);
        check("p5_to_p1_next_per", n, 8 + X);

        // P=7, one-cycle reset in H1, then a full restart period.
        prescale = 8'd7;
        wait_fall();
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_h1_scl", int'(scl_o), 1);
        check("rst_h1_busy", int'(busy), 0);
        check("rst_h1_ticks", int'({fall, chg, rise, smp, str}), 0);
        measure("p7_restart", 8, 16, 24 + X, 32 + X, 16);

`ifdef I2C_CLK_STRETCH_EN
        // P=2 with loopback, then a 10-cycle external stretch.
        prescale = 8'd2;
        measure("p2", 3, 6, 11, 14, 6);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rise && k < 300);
        check("stretch_wait_rise", int'(rise), 1);
        ext_low = 1'b1;
        sc = str ? 1 : 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (str) sc++;
            if (n == 10) ext_low = 1'b0;
        end while (!smp && n < 300);
        check("stretch_rise_to_smp", n, 15);
        check("stretch_cycles", sc, 12);
`endif

        en = 1'b0;
        repeat (40) @(negedge clk);
        check("final_idle_busy", int'(busy), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
